id_stage_fwd: RTL
=================

Name: id_stage_fwd

Overview:
Parametrised next-generation decode stage for the LA32R 5-stage pipeline. It sits between IF and EXE and decodes instructions into control signals. It forwards operands from NUM_FWD younger producer stages and detects load-use hazards internally, stalling itself while one is pending. Branches resolve in this stage with an explicit wrong-path squash, and the ID/EXE pipeline register is built into the block.

Parameters:
NUM_FWD, 3, number of forwarding sources (1..4); index 0 is the youngest (EXE) and has the highest priority.
RESET_PC, 32'h1c000000, reset value of ds_pc and es_pc.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
fs_to_ds_valid  in  1  IF holds a valid instruction
fs_pc  in  32  PC of the IF instruction
fs_inst  in  32  IF instruction word
ds_allow_in  out  1  ID can accept a new instruction this cycle
rf_raddr1  out  5  register-file read address 1 (rj)
rf_raddr2  out  5  register-file read address 2 (rk or rd)
rf_rdata1  in  32  register-file read data 1
rf_rdata2  in  32  register-file read data 2
fwd_we  in  NUM_FWD  per-source write-enable
fwd_is_load  in  NUM_FWD  per-source: result not yet available (load in flight)
fwd_waddr  in  5*NUM_FWD  per-source destination register, packed
fwd_wdata  in  32*NUM_FWD  per-source result, packed
br_taken  out  1  redirect IF (single-cycle pulse)
br_target  out  32  redirect address
es_allow_in  in  1  EXE can accept
es_valid  out  1  EXE slot valid
es_pc  out  32  EXE PC
es_alu_op  out  12  one-hot ALU operation
es_alu_src1  out  32  ALU operand 1
es_alu_src2  out  32  ALU operand 2
es_mem_re  out  1  instruction is a load
es_mem_we  out  4  store byte enables
es_st_data  out  32  store data (forwarded rd value)
es_rf_we  out  1  instruction writes a register
es_rf_waddr  out  5  destination register

Behaviour:
- Decoded set: add.w, sub.w, slt, sltu, nor, and, or, xor, slli.w, srli.w, srai.w, addi.w, ld.w, st.w, jirl, b, bl, beq, bne, blt, bge, bltu, bgeu, lu12i.w. Any other encoding decodes as a NOP: no register write, no memory access, no branch.
- Internal registers:
  - ds_valid, reset 0.
  - ds_pc, reset RESET_PC.
  - ds_inst, reset 0.
- Operand usage:
  - src1 is used by every decoded instruction except b, bl and lu12i.w.
  - src2 is used by 3R ALU ops (read from rk), by conditional branches and by st.w (read from rd).
- Forwarding per operand:
  - Source i hits when fwd_we[i] is set, fwd_waddr[i] is non-zero and fwd_waddr[i] equals the read address.
  - The lowest-index hit wins; with no hit, the register-file data is used.
  - Address r0 always reads 0.
- Hazard and stall:
  - hazard = the operand is used AND the winning hit has fwd_is_load set.
  - ds_ready_go = !hazard.
- Handshakes:
  - ds_allow_in = !ds_valid | (ds_ready_go & es_allow_in).
  - ds_to_es = ds_valid & ds_ready_go & es_allow_in.
- Branch resolution:
  - br_taken = ds_to_es & take. For conditional branches, take is the comparison result on forwarded values; jirl, b and bl are always taken.
  - br_target is combinational: pc+offs16<<2 for conditional branches, pc+offs26<<2 for b/bl, rj_fwd+offs16<<2 for jirl.
  - br_taken is never asserted while ds_valid=0 or while the stage is stalled.
- ID register update, in priority order:
  1. br_taken: ds_valid<=0, and any simultaneous IF instruction is discarded (wrong path).
  2. ds_allow_in: ds_valid<=fs_to_ds_valid; ds_pc and ds_inst are loaded when fs_to_ds_valid is set.
  3. Otherwise hold all state.
- EXE register:
  - On es_allow_in: es_valid<=ds_to_es, and the payload loads when ds_to_es.
  - Otherwise everything holds.
  - Reset values: every es_* output is 0 except es_pc=RESET_PC.
- Operand mapping:
  - alu_src1 is the PC for jirl and bl, otherwise rj_fwd.
  - alu_src2:
    - 4 for jirl and bl.
    - Sign-extended si12 for addi.w, ld.w and st.w.
    - ui5 for shift-immediate ops.
    - {si20,12'b0} for lu12i.w.
    - Otherwise src2_fwd.
  - es_mem_we = 4'hf for st.w; es_st_data = rd_fwd.
- Destination: es_rf_waddr is 1 for bl, rd otherwise. es_rf_we is 0 for stores, conditional branches, b, NOPs, and whenever the destination is r0.
- Boundary conditions:
  - A hazard combined with a branch: the branch waits, with br_taken held at 0.
  - es_allow_in=0 while ds_valid=1: the stage holds and IF is back-pressured.
  - Reset mid-stall: all valids clear immediately, asynchronously.

Optional Feature:
HAZARD_STAT_EN.
- When defined, the block adds two outputs:
  - stall_cnt (32): increments each cycle with ds_valid & hazard.
  - flush_cnt (32): increments on br_taken.
- Both counters reset to 0 and wrap at 2^32.
- When undefined, neither port nor the counters exist, and behaviour is otherwise identical.

Test Plan:
- addi.w r1,r0,5 followed immediately by add.w r2,r1,r1, with fwd index0 driving r1=5 -> es_alu_src1=es_alu_src2=5 with no stall.
- ld.w r3 in EXE (fwd_is_load[0]=1, waddr=3) while ID holds add.w r4,r3,r0 -> ds_ready_go=0 for 1 cycle and es_valid=0 bubble. Next cycle, with the source at index1 and is_load=0 carrying 0x1234 -> es_alu_src1=0x1234.
- beq r5,r6 with both forwarded as 7 at pc 0x1c000010, offs16=4 -> br_taken=1 for one cycle, br_target=0x1c000020, and the concurrent fs instruction is squashed (ds_valid=0 the next cycle).
- Two sources both matching r7 (index0=0xA, index2=0xB) -> operand = 0xA.
- es_allow_in=0 for 3 cycles with a valid jirl in ID -> br_taken stays 0 and es_* hold their values. On release, br_taken pulses exactly once.
- resetn asserted low mid-stall -> ds_valid=es_valid=0 and es_pc=0x1c000000 asynchronously. With HAZARD_STAT_EN defined, stall_cnt=0.

Source files
------------

// File: rtl/id_stage_fwd.sv
// rtl/id_stage_fwd.sv - LA32R decode stage with operand forwarding, load-use stall, branch resolve and ID/EXE register.
// Optional HAZARD_STAT_EN adds stall_cnt / flush_cnt statistics outputs.
module id_stage_fwd #(
    parameter int          NUM_FWD  = 3,
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   fs_to_ds_valid,
    input  logic [31:0]            fs_pc,
    input  logic [31:0]            fs_inst,
    output logic                   ds_allow_in,
    output logic [4:0]             rf_raddr1,
    output logic [4:0]             rf_raddr2,
    input  logic [31:0]            rf_rdata1,
    input  logic [31:0]            rf_rdata2,
    input  logic [NUM_FWD-1:0]     fwd_we,
    input  logic [NUM_FWD-1:0]     fwd_is_load,
    input  logic [5*NUM_FWD-1:0]   fwd_waddr,
    input  logic [32*NUM_FWD-1:0]  fwd_wdata,
    output logic                   br_taken,
    output logic [31:0]            br_target,
    input  logic                   es_allow_in,
    output logic                   es_valid,
    output logic [31:0]            es_pc,
    output logic [11:0]            es_alu_op,
    output logic [31:0]            es_alu_src1,
    output logic [31:0]            es_alu_src2,
    output logic                   es_mem_re,
    output logic [3:0]             es_mem_we,
    output logic [31:0]            es_st_data,
    output logic                   es_rf_we,
    output logic [4:0]             es_rf_waddr
`ifdef HAZARD_STAT_EN
    ,
    output logic [31:0]            stall_cnt,
    output logic [31:0]            flush_cnt
`endif
);

    logic        r_ds_valid;
    logic [31:0] r_ds_pc;
    logic [31:0] r_ds_inst;

    logic [4:0]  w_rd, w_rj, w_rk;
    assign w_rd = r_ds_inst[4:0];
    assign w_rj = r_ds_inst[9:5];
    assign w_rk = r_ds_inst[14:10];

    logic w_add, w_sub, w_slt, w_sltu, w_nor, w_and, w_or, w_xor;
    logic w_slli, w_srli, w_srai, w_addi, w_ld, w_st, w_lu12i;
    logic w_jirl, w_b, w_bl, w_beq, w_bne, w_blt, w_bge, w_bltu, w_bgeu;
    assign w_add   = r_ds_inst[31:15] == 17'h00020;
    assign w_sub   = r_ds_inst[31:15] == 17'h00022;
    assign w_slt   = r_ds_inst[31:15] == 17'h00024;
    assign w_sltu  = r_ds_inst[31:15] == 17'h00025;
    assign w_nor   = r_ds_inst[31:15] == 17'h00028;
    assign w_and   = r_ds_inst[31:15] == 17'h00029;
    assign w_or    = r_ds_inst[31:15] == 17'h0002a;
    assign w_xor   = r_ds_inst[31:15] == 17'h0002b;
    assign w_slli  = r_ds_inst[31:15] == 17'h00081;
    assign w_srli  = r_ds_inst[31:15] == 17'h00089;
    assign w_srai  = r_ds_inst[31:15] == 17'h00091;
    assign w_addi  = r_ds_inst[31:22] == 10'h00a;
    assign w_ld    = r_ds_inst[31:22] == 10'h0a2;
    assign w_st    = r_ds_inst[31:22] == 10'h0a6;
    assign w_lu12i = r_ds_inst[31:25] == 7'h0a;
    assign w_jirl  = r_ds_inst[31:26] == 6'h13;
    assign w_b     = r_ds_inst[31:26] == 6'h14;
    assign w_bl    = r_ds_inst[31:26] == 6'h15;
    assign w_beq   = r_ds_inst[31:26] == 6'h16;
    assign w_bne   = r_ds_inst[31:26] == 6'h17;
    assign w_blt   = r_ds_inst[31:26] == 6'h18;
    assign w_bge   = r_ds_inst[31:26] == 6'h19;
    assign w_bltu  = r_ds_inst[31:26] == 6'h1a;
    assign w_bgeu  = r_ds_inst[31:26] == 6'h1b;

    logic w_is_3r, w_is_shi, w_is_cbr, w_link, w_src1_used, w_src2_used;
    assign w_is_3r     = w_add | w_sub | w_slt | w_sltu | w_nor | w_and | w_or | w_xor;
    assign w_is_shi    = w_slli | w_srli | w_srai;
    assign w_is_cbr    = w_beq | w_bne | w_blt | w_bge | w_bltu | w_bgeu;
    assign w_link      = w_jirl | w_bl;
    assign w_src1_used = w_is_3r | w_is_shi | w_addi | w_ld | w_st | w_jirl | w_is_cbr;
    assign w_src2_used = w_is_3r | w_is_cbr | w_st;

    // Conditional branches and stores compare/store the rd register, so port 2 reads rd for them.
    assign rf_raddr1 = w_rj;
    assign rf_raddr2 = (w_is_cbr | w_st) ? w_rd : w_rk;

    logic [31:0] w_src1_fwd, w_src2_fwd;
    logic        w_src1_ld, w_src2_ld;
    always_comb begin
        w_src1_fwd = rf_rdata1;
        w_src2_fwd = rf_rdata2;
        w_src1_ld  = 1'b0;
        w_src2_ld  = 1'b0;
        // Walk oldest to youngest so the lowest-index hit is the last one written.
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && (fwd_waddr[i*5 +: 5] != 5'd0) && (fwd_waddr[i*5 +: 5] == rf_raddr1)) begin
                w_src1_fwd = fwd_wdata[i*32 +: 32];
                w_src1_ld  = fwd_is_load[i];
            end
            if (fwd_we[i] && (fwd_waddr[i*5 +: 5] != 5'd0) && (fwd_waddr[i*5 +: 5] == rf_raddr2)) begin
                w_src2_fwd = fwd_wdata[i*32 +: 32];
                w_src2_ld  = fwd_is_load[i];
            end
        end
        if (rf_raddr1 == 5'd0) begin
            w_src1_fwd = 32'd0;
        end
        if (rf_raddr2 == 5'd0) begin
            w_src2_fwd = 32'd0;
        end
    end

    logic w_hazard, w_ds_ready_go, w_ds_to_es;
    assign w_hazard      = (w_src1_used & w_src1_ld) | (w_src2_used & w_src2_ld);
    assign w_ds_ready_go = ~w_hazard;
    assign ds_allow_in   = ~r_ds_valid | (w_ds_ready_go & es_allow_in);
    assign w_ds_to_es    = r_ds_valid & w_ds_ready_go & es_allow_in;

    logic        w_eq, w_lt_s, w_lt_u, w_take;
    logic [31:0] w_offs16, w_offs26;
    assign w_eq     = w_src1_fwd == w_src2_fwd;
    assign w_lt_s   = $signed(w_src1_fwd) < $signed(w_src2_fwd);
    assign w_lt_u   = w_src1_fwd < w_src2_fwd;
    assign w_take   = w_jirl | w_b | w_bl
                    | (w_beq & w_eq) | (w_bne & ~w_eq)
                    | (w_blt & w_lt_s) | (w_bge & ~w_lt_s)
                    | (w_bltu & w_lt_u) | (w_bgeu & ~w_lt_u);
    assign w_offs16 = {{14{r_ds_inst[25]}}, r_ds_inst[25:10], 2'b00};
    assign w_offs26 = {{4{r_ds_inst[9]}}, r_ds_inst[9:0], r_ds_inst[25:10], 2'b00};

    assign br_taken  = w_ds_to_es & w_take;
    assign br_target = w_jirl ? (w_src1_fwd + w_offs16)
                     : (w_b | w_bl) ? (r_ds_pc + w_offs26)
                     : (r_ds_pc + w_offs16);

    logic [11:0] w_alu_op;
    logic [31:0] w_alu_src1, w_alu_src2;
    logic [4:0]  w_dest;
    logic        w_rf_we;
    assign w_alu_op   = {w_lu12i, w_srai, w_srli, w_slli, w_xor, w_or, w_nor, w_and,
                         w_sltu, w_slt, w_sub, w_add | w_addi | w_ld | w_st | w_link};
    assign w_alu_src1 = w_link ? r_ds_pc : w_src1_fwd;
    assign w_alu_src2 = w_link ? 32'd4
                      : (w_addi | w_ld | w_st) ? {{20{r_ds_inst[21]}}, r_ds_inst[21:10]}
                      : w_is_shi ? {27'd0, r_ds_inst[14:10]}
                      : w_lu12i ? {r_ds_inst[24:5], 12'd0}
                      : w_src2_fwd;
    assign w_dest     = w_bl ? 5'd1 : w_rd;
    assign w_rf_we    = (w_is_3r | w_is_shi | w_addi | w_ld | w_link | w_lu12i) & (w_dest != 5'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ds_valid <= 1'b0;
            r_ds_pc    <= RESET_PC;
            r_ds_inst  <= 32'd0;
        end else if (br_taken) begin
            r_ds_valid <= 1'b0;
        end else if (ds_allow_in) begin
            r_ds_valid <= fs_to_ds_valid;
            if (fs_to_ds_valid) begin
                r_ds_pc   <= fs_pc;
                r_ds_inst <= fs_inst;
            end
        end
    end

    logic        r_es_valid, r_es_mem_re, r_es_rf_we;
    logic [31:0] r_es_pc, r_es_alu_src1, r_es_alu_src2, r_es_st_data;
    logic [11:0] r_es_alu_op;
    logic [3:0]  r_es_mem_we;
    logic [4:0]  r_es_rf_waddr;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_es_valid    <= 1'b0;
            r_es_pc       <= RESET_PC;
            r_es_alu_op   <= 12'd0;
            r_es_alu_src1 <= 32'd0;
            r_es_alu_src2 <= 32'd0;
            r_es_mem_re   <= 1'b0;
            r_es_mem_we   <= 4'd0;
            r_es_st_data  <= 32'd0;
            r_es_rf_we    <= 1'b0;
            r_es_rf_waddr <= 5'd0;
        end else if (es_allow_in) begin
            r_es_valid <= w_ds_to_es;
            if (w_ds_to_es) begin
                r_es_pc       <= r_ds_pc;
                r_es_alu_op   <= w_alu_op;
                r_es_alu_src1 <= w_alu_src1;
                r_es_alu_src2 <= w_alu_src2;
                r_es_mem_re   <= w_ld;
                r_es_mem_we   <= w_st ? 4'hf : 4'h0;
                r_es_st_data  <= w_src2_fwd;
                r_es_rf_we    <= w_rf_we;
                r_es_rf_waddr <= w_dest;
            end
        end
    end

    assign es_valid    = r_es_valid;
    assign es_pc       = r_es_pc;
    assign es_alu_op   = r_es_alu_op;
    assign es_alu_src1 = r_es_alu_src1;
    assign es_alu_src2 = r_es_alu_src2;
    assign es_mem_re   = r_es_mem_re;
    assign es_mem_we   = r_es_mem_we;
    assign es_st_data  = r_es_st_data;
    assign es_rf_we    = r_es_rf_we;
    assign es_rf_waddr = r_es_rf_waddr;

`ifdef HAZARD_STAT_EN
    logic [31:0] r_stall_cnt, r_flush_cnt;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (r_ds_valid && w_hazard) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (br_taken) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
